// File: rtl/flag_pkg.sv
// Shared definitions for the flag register and its save/restore stack.
package flag_pkg;

    // ALU operation encodings
    typedef enum logic [1:0] {
        AluAdd   = 2'b00,
        AluSub   = 2'b01,
        AluLogic = 2'b10,
        AluPass  = 2'b11
    } alu_op_e;

    // Bit positions inside the packed {n,z,c,v} flag vector
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;
    localparam int unsigned FLAG_W = 4;

    localparam int unsigned STK_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/flag_stack.sv
// Small LIFO holding saved flag vectors, with occupancy and sticky misuse status.
module flag_stack
    import flag_pkg::*;
#(
    parameter int unsigned STK_DEPTH = STK_DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [FLAG_W-1:0] wdata,
    output logic [FLAG_W-1:0] rdata,
    output logic              pop_ok,
    output logic              full,
    output logic              empty,
    output logic              err
);

    localparam int unsigned AW = $clog2(STK_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [CW-1:0]     count_q, count_d;
    logic              err_q, err_d;
    logic [FLAG_W-1:0] mem_q [STK_DEPTH];
    logic [FLAG_W-1:0] mem_d [STK_DEPTH];
    logic              push_ok;
    logic [CW-1:0]     top_idx;

    // Status decode and top-of-stack read
    always_comb begin
        full    = (count_q == CW'(STK_DEPTH));
        empty   = (count_q == '0);
        // Simultaneous push and pop is treated as misuse: neither takes effect
        push_ok = push & ~pop & ~full;
        pop_ok  = pop & ~push & ~empty;
        top_idx = count_q - CW'(1);
        rdata   = mem_q[top_idx[AW-1:0]];
        err     = err_q;
    end

    // Next-state for pointer, contents and sticky error
    always_comb begin
        count_d = count_q;
        mem_d   = mem_q;
        err_d   = err_q | (push & pop) | (push & full) | (pop & empty);
        if (push_ok) begin
            mem_d[count_q[AW-1:0]] = wdata;
            count_d                = count_q + CW'(1);
        end else if (pop_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointer and error state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Storage is not reset; entries above the pointer are never read as valid
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/flag_reg.sv
// Condition-flag register: ALU flag generation, explicit load and LIFO save/restore.
module flag_reg
    import flag_pkg::*;
#(
    parameter int unsigned STK_DEPTH = STK_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic        set_flags,
    input  logic [1:0]  alu_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] res,
    input  logic        ld_flags,
    input  logic [3:0]  ld_val,
    input  logic        push,
    input  logic        pop,
    output logic        n,
    output logic        z,
    output logic        c,
    output logic        v,
    output logic        flags_valid,
    output logic        stk_full,
    output logic        stk_empty,
    output logic        stk_err
);

    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              valid_q, valid_d;
    logic [FLAG_W-1:0] alu_flags;
    logic [FLAG_W-1:0] stk_top;
    logic              pop_ok;
    logic              alu_wr;
    logic [31:0]       add_lo;

    flag_stack #(
        .STK_DEPTH(STK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (flags_q),
        .rdata (stk_top),
        .pop_ok(pop_ok),
        .full  (stk_full),
        .empty (stk_empty),
        .err   (stk_err)
    );

    // Flags an ALU result would produce; c and v hold for logic/pass
    always_comb begin
        alu_flags         = flags_q;
        // Low 32 bits of a+b wrap below a exactly when the 33-bit sum carries out
        add_lo            = a + b;
        alu_flags[FLAG_N] = res[31];
        alu_flags[FLAG_Z] = (res == '0);
        unique case (alu_op_e'(alu_op))
            AluAdd: begin
                alu_flags[FLAG_C] = (add_lo < a);
                alu_flags[FLAG_V] = (a[31] == b[31]) & (res[31] != a[31]);
            end
            AluSub: begin
                // Carry means no borrow
                alu_flags[FLAG_C] = (a >= b);
                alu_flags[FLAG_V] = (a[31] != b[31]) & (res[31] != a[31]);
            end
            AluLogic, AluPass: begin
            end
        endcase
    end

    // Write-source selection: restore beats explicit load beats ALU update
    always_comb begin
        alu_wr  = alu_valid & set_flags;
        flags_d = flags_q;
        if (pop_ok) begin
            flags_d = stk_top;
        end else if (ld_flags) begin
            flags_d = ld_val;
        end else if (alu_wr) begin
            flags_d = alu_flags;
        end
        valid_d = valid_q | pop_ok | ld_flags | alu_wr;
    end

    // Flag and valid registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
            valid_q <= 1'b0;
        end else begin
            flags_q <= flags_d;
            valid_q <= valid_d;
        end
    end

    assign n           = flags_q[FLAG_N];
    assign z           = flags_q[FLAG_Z];
    assign c           = flags_q[FLAG_C];
    assign v           = flags_q[FLAG_V];
    assign flags_valid = valid_q;

endmodule
